// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed, big-endian byte stream,
// assembles 32-bit words and writes them to consecutive word addresses while the
// CPU pipeline is held in reset. Releases the CPU once the whole program is loaded.
module imem_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        StIdle,
        StHdrHi,
        StHdrLo,
        StData,
        StWrite,
        StDone,
        StError
    } state_e;

    state_e      state_q;
    state_e      state_d;
    logic [15:0] count_q;
    logic [16:0] word_cnt_q;
    logic [1:0]  byte_cnt_q;
    logic [23:0] word_q;

    logic        accept;
    logic [15:0] hdr_count;
    logic        hdr_bad;
    logic        last_word;

    assign accept    = byte_valid & byte_ready;
    assign hdr_count = {count_q[15:8], byte_data};
    assign hdr_bad   = (hdr_count == 16'd0) || (32'(hdr_count) > MAX_WORDS);
    // Word counter is one bit wider than the header so the compare never aliases.
    assign last_word = (word_cnt_q + 17'd1) == {1'b0, count_q};

    // Next-state decode; every state stalls until its acceptance condition holds.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) state_d = StHdrHi;
            end
            StHdrHi: begin
                if (accept) state_d = StHdrLo;
            end
            StHdrLo: begin
                if (accept) state_d = hdr_bad ? StError : StData;
            end
            StData: begin
                if (accept && (byte_cnt_q == 2'd3)) state_d = StWrite;
            end
            StWrite: begin
                state_d = last_word ? StDone : StData;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            state_q    <= state_d;
            byte_ready <= (state_d == StHdrHi) || (state_d == StHdrLo) || (state_d == StData);
            imem_we    <= (state_d == StWrite);
            done       <= (state_d == StDone);
            error      <= (state_d == StError);
            cpu_hold   <= (state_d != StDone);
        end
    end

    // Header capture, word assembly and address/word counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q    <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone, StError: begin
                    if (start) begin
                        word_cnt_q <= '0;
                        byte_cnt_q <= '0;
                        imem_addr  <= '0;
                    end
                end
                StHdrHi: begin
                    if (accept) count_q[15:8] <= byte_data;
                end
                StHdrLo: begin
                    if (accept) count_q[7:0] <= byte_data;
                end
                StData: begin
                    if (accept) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        unique case (byte_cnt_q)
                            2'd0: word_q[23:16] <= byte_data;
                            2'd1: word_q[15:8]  <= byte_data;
                            2'd2: word_q[7:0]   <= byte_data;
                            // The last byte completes the word straight into the
                            // write-data register, which then holds until the next word.
                            default: imem_wdata <= {word_q, byte_data};
                        endcase
                    end
                end
                StWrite: begin
                    word_cnt_q <= word_cnt_q + 17'd1;
                    imem_addr  <= imem_addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal load, header rejection, throttled
// stream, mid-word reset and start-during-load.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int we_ready_bad = 0;
    logic [7:0]  wr_addr [16];
    logic [31:0] wr_data [16];
    int t0;
    int tmo;

    imem_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every write strobe, and flag any write cycle that also offers byte_ready.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_cnt < 16) begin
                wr_addr[wr_cnt] = imem_addr;
                wr_data[wr_cnt] = imem_wdata;
            end
            wr_cnt = wr_cnt + 1;
            if (byte_ready !== 1'b0) we_ready_bad = we_ready_bad + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("byte_timeout", (n >= 50) ? 32'd1 : 32'd0, 32'd0);
        @(negedge clk);
    endtask

    task automatic send_gap(input logic [7:0] b);
        send_byte(b);
        byte_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", (n >= 100) ? 32'd1 : 32'd0, 32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(byte_ready), 32'd0);

        // Two-word back-to-back load; latency from first header byte to DONE
        pulse_start();
        chk("hdr_ready", 32'(byte_ready), 32'd1);
        t0 = cyc;
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h8C); send_byte(8'h09); send_byte(8'h00); send_byte(8'h04);
        byte_valid = 1'b0;
        wait_done();
        chk("s1_latency", 32'(cyc - t0), 32'd12);
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_hold", 32'(cpu_hold), 32'd0);
        chk("s1_error", 32'(error), 32'd0);
        chk("s1_wrcnt", 32'(wr_cnt), 32'd2);
        chk("s1_addr0", 32'(wr_addr[0]), 32'd0);
        chk("s1_data0", wr_data[0], 32'h20080005);
        chk("s1_addr1", 32'(wr_addr[1]), 32'd1);
        chk("s1_data1", wr_data[1], 32'h8C090004);
        chk("s1_wdata_hold", imem_wdata, 32'h8C090004);
        repeat (3) @(negedge clk);
        chk("s1_done_stays", 32'(done), 32'd1);

        // Zero-length header rejected
        pulse_start();
        chk("s2_done_clr", 32'(done), 32'd0);
        send_byte(8'h00); send_byte(8'h00);
        byte_valid = 1'b0;
        chk("s2_error", 32'(error), 32'd1);
        chk("s2_hold", 32'(cpu_hold), 32'd1);
        chk("s2_ready", 32'(byte_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("s2_wrcnt", 32'(wr_cnt), 32'd2);
        pulse_start();
        chk("s2_err_clr", 32'(error), 32'd0);
        chk("s2_rehdr", 32'(byte_ready), 32'd1);

        // 257 words rejected
        send_byte(8'h01); send_byte(8'h01);
        byte_valid = 1'b0;
        chk("s3_error", 32'(error), 32'd1);
        repeat (3) @(negedge clk);
        chk("s3_wrcnt", 32'(wr_cnt), 32'd2);

        // 256 words accepted, then reset after two data bytes of word 0
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        chk("s4_max_ok", 32'(error), 32'd0);
        chk("s4_data_ready", 32'(byte_ready), 32'd1);
        send_byte(8'hAA); send_byte(8'hBB);
        byte_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("s4_hold", 32'(cpu_hold), 32'd1);
        chk("s4_ready", 32'(byte_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("s4_nowrite", 32'(wr_cnt), 32'd2);
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        byte_valid = 1'b0;
        wait_done();
        chk("s4_wrcnt", 32'(wr_cnt), 32'd3);
        chk("s4_addr", 32'(wr_addr[2]), 32'd0);
        chk("s4_data", wr_data[2], 32'hDEADBEEF);

        // Throttled stream: byte_valid toggles every cycle
        pulse_start();
        send_gap(8'h00); send_gap(8'h01);
        send_gap(8'h12); send_gap(8'h34); send_gap(8'h56); send_gap(8'h78);
        wait_done();
        chk("s5_wrcnt", 32'(wr_cnt), 32'd4);
        chk("s5_addr", 32'(wr_addr[3]), 32'd0);
        chk("s5_data", wr_data[3], 32'h12345678);

        // Start during DATA is ignored
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h11);
        byte_valid = 1'b0;
        pulse_start();
        chk("s6_in_data", 32'(byte_ready), 32'd1);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        byte_valid = 1'b0;
        wait_done();
        chk("s6_wrcnt", 32'(wr_cnt), 32'd5);
        chk("s6_addr", 32'(wr_addr[4]), 32'd0);
        chk("s6_data", wr_data[4], 32'h11223344);

        chk("we_ready_overlap", 32'(we_ready_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute backstop so the run can never hang.
    initial begin
        tmo = 0;
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
